// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam int         DEPTH_DEF = 512;
    localparam int         AW_DEF    = 12;
    localparam logic [3:0] BE_NONE   = 4'b0000;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-request arbiter: round-robin on last winner, or fixed M0 priority when
// MEM_ARB_FIXED_PRIO_EN is defined (pointer register removed).
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_arb;
    assign unused_arb = ^{clk, clr, upd_i};
    assign gnt_o      = {req_i[M1] & ~req_i[M0], req_i[M0]};
`else
    // ptr_q holds the master that won last; reset to M1 so M0 takes the first tie
    logic ptr_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11)
            gnt_o = (ptr_q == M1) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!clr)
            ptr_q <= M1;
        else if (upd_i && (|req_i))
            ptr_q <= gnt_o[M1];
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between M0 (LSU) and M1 (debug loader).
// IDLE -> ISSUE -> RESP; tie policy set by MEM_ARB_FIXED_PRIO_EN (see rr_arb2).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_be,
    output logic          m0_ack,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_be,
    output logic          m1_ack,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_datain,
    output logic [3:0]    mem_sel,
    output logic          mem_str,
    output logic          mem_ld,
    input  logic [31:0]   mem_dataout
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_q;
    logic          mst_q, ack_q, err_q, rd_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          str_q, ld_q;

    logic [1:0]    req, gnt;
    logic          win, w_we, w_oor, w_go;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;

    assign req = {m1_req, m0_req};

    rr_arb2 u_arb (
        .clk   (clk),
        .clr   (clr),
        .req_i (req),
        .upd_i (state_q == IDLE),
        .gnt_o (gnt)
    );

    assign win     = gnt[M1];
    assign w_we    = (win == M1) ? m1_we    : m0_we;
    assign w_addr  = (win == M1) ? m1_addr  : m0_addr;
    assign w_wdata = (win == M1) ? m1_wdata : m0_wdata;
    assign w_be    = (win == M1) ? m1_be    : m0_be;
    assign w_oor   = {1'b0, w_addr} >= DEPTH_W;
    // Empty lane mask or bad address: the access is acked but never touches memory
    assign w_go    = !w_oor && (w_be != BE_NONE);

    // Memory strobes are loaded on the grant edge so they are high exactly in ISSUE
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            mst_q   <= M0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            str_q   <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            str_q <= 1'b0;
            ld_q  <= 1'b0;
            be_q  <= '0;
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= ISSUE;
                        mst_q   <= win;
                        err_q   <= w_oor;
                        rd_q    <= w_go & ~w_we;
                        addr_q  <= w_addr;
                        wdata_q <= w_wdata;
                        be_q    <= w_be;
                        str_q   <= w_go & w_we;
                        ld_q    <= w_go & ~w_we;
                    end
                end
                ISSUE: begin
                    state_q <= RESP;
                    ack_q   <= 1'b1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr   = addr_q;
    assign mem_datain = wdata_q;
    assign mem_sel    = be_q;
    assign mem_str    = str_q;
    assign mem_ld     = ld_q;

    // Reset arriving in the RESP cycle aborts the access, so the ack is masked by clr
    logic live0, live1;
    assign live0 = ack_q & clr & (mst_q == M0);
    assign live1 = ack_q & clr & (mst_q == M1);

    assign m0_ack   = live0;
    assign m1_ack   = live1;
    assign m0_err   = live0 & err_q;
    assign m1_err   = live1 & err_q;
    assign m0_rdata = (live0 && rd_q) ? mem_dataout : '0;
    assign m1_rdata = (live1 && rd_q) ? mem_dataout : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: M0 (CPU load/store unit) and M1 (debug/program loader).
- Round-robin arbitration.
- Sequences each access into the memory's str/ld/sel/addr/datain strobes and returns load data with a valid/ack handshake.
- Sits between the requesters and dataMemory. All memory-side outputs are registered.

Parameters:
- DEPTH, 512, number of 32-bit words implemented; word addresses >= DEPTH are out of range.
- AW, 12, word-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-low.
- m0_req  in  1  M0 command valid.
- m0_we  in  1  1 = store, 0 = load.
- m0_addr  in  AW  M0 word address.
- m0_wdata  in  32  M0 store data.
- m0_be  in  4  M0 byte enables (bit i = byte lane i).
- m0_ack  out  1  one-cycle completion pulse to M0.
- m0_rdata  out  32  M0 load data, valid when m0_ack.
- m0_err  out  1  M0 out-of-range flag, valid when m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_ack, m1_rdata, m1_err: same as M0, for M1.
- mem_addr  out  AW  to memory addr.
- mem_datain  out  32  to memory datain.
- mem_sel  out  4  to memory sel.
- mem_str  out  1  to memory str.
- mem_ld  out  1  to memory ld.
- mem_dataout  in  32  from memory; registered inside memory, valid one cycle after ld.

Behaviour:
- Reset (clr=0 at an edge):
  - state=IDLE; rr pointer=M1, so M0 wins the first tie.
  - All ack/err=0, rdata=0.
  - mem_str=mem_ld=0, mem_sel=0, mem_addr=0, mem_datain=0.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. Every state lasts exactly one cycle except IDLE.
- IDLE:
  - Samples req only here.
  - If any req is set: pick the winner, latch its we/addr/wdata/be into command registers, go to ISSUE.
  - If no req: stay in IDLE.
- ISSUE: drives the latched command onto the memory outputs.
  - Store: mem_str=1.
  - Load: mem_ld=1.
  - mem_sel=be, mem_addr=addr, mem_datain=wdata.
- RESP:
  - Strobes return to 0.
  - Winner's ack=1 for this cycle only. For a load, rdata = mem_dataout; for a store, rdata = 0.
  - Go to IDLE.
- Latency: req seen at edge k -> strobe high in cycle k+1 -> ack in cycle k+2. Throughput is one access per 3 cycles under continuous load.
- Handshake:
  - Requester holds req and its command stable until ack.
  - Requester deasserts req at the edge ending the ack cycle, unless it presents a new command. A still-high req in IDLE is a new access.
- Arbitration: if both req are set in IDLE, grant the master that did not win last. The pointer updates only on a grant. Worst-case wait is one access (<=6 cycles to ack).
- Boundary conditions:
  - be=4'b0000: access still acked; no strobe issued; rdata=0; err=0.
  - addr >= DEPTH: no strobe issued; ack with err=1 and rdata=0.
  - Loads zero disabled lanes, since the memory already clears dataout.
  - Non-winning master's ack/err stay 0 while the other is served.
- Reset mid-operation:
  - State is aborted and no ack is produced.
  - If clr is low in the ISSUE cycle, the store strobe is already presented to the memory at that edge and commits (memory is not reset).
  - The first access after reset always starts from IDLE.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, M0 always wins a tie; the rr pointer is removed. M1 may starve while M0 req stays high.
- Undefined: round-robin as described above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - constants DEPTH_DEF=512, AW_DEF=12, BE_NONE=4'b0000;
  - master index constants M0=0, M1=1.
- One natural sub-module: rr_arb2.
  - Two-request round-robin grant with pointer register, update-enable input, and fixed-priority mode selected by the macro.
- FSM and command registers stay in the top module.

Test Plan:
- Store then load, M0 only: m0 stores addr=5, wdata=0xDEADBEEF, be=4'hF (mem_str high in cycle k+1, m0_ack in k+2); then loads addr=5, be=4'hF -> m0_rdata=0xDEADBEEF with m0_ack.
- Partial lanes: store 0x11223344 be=4'hF, then store 0xAABBCCDD be=4'b0101 to the same address; load with be=4'hF -> 0x11BB33DD. Load with be=4'b0010 -> 0x00003300.
- Contention: m0_req and m1_req held high continuously for 6 accesses -> grants alternate M0, M1, M0, M1, M0, M1. With MEM_ARB_FIXED_PRIO_EN -> all 6 go to M0.
- Out of range and no-op: m1 load addr=600 -> m1_ack with m1_err=1, rdata=0, and mem_ld never high. m0 store be=0 -> m0_ack, mem_str never high, memory unchanged.
- Reset mid-access: clr=0 during the RESP cycle of an M0 load -> no m0_ack, all outputs 0 next cycle. A subsequent M1 request wins first only if M0 is idle; with both requesting after reset, M0 wins.
- Handshake hold: M0 keeps req high one extra cycle after ack with a new command (addr=7) -> second access issues exactly once, ack in the correct order.
